multiplicador_algoritmico: RTL and testbench

MULTIPLICADOR_ALGORITMICO -- requirements
Module: multiplicador_algoritmico

---
 rtl/multiplicador_algoritmico.sv | 153 +++++++++++++++
 tb/tb_multiplicador_algoritmico.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/multiplicador_algoritmico.sv
// -----------------------------------------------------------------------------
// multiplicador_algoritmico
//
// Sequential signed multiplier using shift-and-add on operand magnitudes.
// The sign of the result is stored separately and applied once, when the
// product is written.
//
// Parameters
//   tamanyo : operand width in bits (>= 2). Producto is 2*tamanyo bits wide.
//
// Ports
//   CLK      in   clock; every state change happens on its rising edge
//   RSTa     in   asynchronous active-high reset
//   Start    in   begin a multiplication (only looked at in IDLE)
//   A, B     in   signed operands, sampled on the edge that accepts Start
//   Producto out  registered signed product A*B, held until the next result
//   Done     out  registered one-cycle pulse on the edge Producto updates
//
// Configuration macro
//   MULT_EARLY_EXIT_EN : when defined, the iteration phase stops as soon as
//   the shifted multiplier reaches zero. The product is the same either way;
//   only the latency gets shorter.
//
// Timing (macro undefined): Start accepted at edge E -> Producto/Done update
// at edge E+tamanyo+1.
// -----------------------------------------------------------------------------
module multiplicador_algoritmico #(
  parameter int tamanyo = 32
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     A,
  input  logic [tamanyo-1:0]     B,
  output logic [2*tamanyo-1:0]   Producto,
  output logic                   Done
);

  // Counter holds values tamanyo down to 0.
  localparam int CW = $clog2(tamanyo + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [2*tamanyo-1:0] mcand;   // |A| zero-extended, shifted left each step
  logic [tamanyo-1:0]   mplier;  // |B|, shifted right each step
  logic [2*tamanyo-1:0] acc;     // partial sum of magnitudes
  logic [CW-1:0]        cnt;     // remaining iterations
  logic                 sign;    // result is negative when set

  logic [tamanyo-1:0]   a_mag;
  logic [tamanyo-1:0]   b_mag;
  logic [2*tamanyo-1:0] prod_signed;
  logic                 last_iter;

  // Two's-complement magnitude. For the most negative value the negation
  // wraps back to 1000..0, which read as unsigned is exactly 2^(tamanyo-1).
  assign a_mag = A[tamanyo-1] ? (~A + 1'b1) : A;
  assign b_mag = B[tamanyo-1] ? (~B + 1'b1) : B;

  // Negating a zero accumulator gives zero again, so no negative zero.
  assign prod_signed = sign ? (~acc + 1'b1) : acc;

`ifdef MULT_EARLY_EXIT_EN
  // Remaining multiplier bits are all zero after this shift: nothing more
  // can be added, so the accumulator already holds the full magnitude.
  assign last_iter = (cnt == CW'(1)) || ((mplier >> 1) == '0);
`else
  assign last_iter = (cnt == CW'(1));
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // simulation and mismatch with synthesis.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) state <= IDLE;
    else      state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so every path assigns it;
  // a missing assignment on any path would infer a latch.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: next_state = Start ? ITER : IDLE;
      ITER: next_state = last_iter ? FIN : ITER;
      FIN:  next_state = IDLE;
      default: next_state = IDLE;   // unused encoding recovers to IDLE
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand registers, accumulator and counter
  // ---------------------------------------------------------------------------
  // NOTE: all datapath registers are reset, not just the control state, so an
  // aborted operation leaves no stale operands or partial sums behind.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mcand  <= {{tamanyo{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= CW'(tamanyo);
            sign   <= A[tamanyo-1] ^ B[tamanyo-1];
          end
        end
        ITER: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        default: ;  // FIN and unused encodings leave the datapath alone
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // Done is high only on the edge leaving FIN; every other edge (including all
  // IDLE edges) clears it, giving a single-cycle pulse. Producto only changes
  // in FIN, so it holds between results.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      Producto <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= (state == FIN);
      if (state == FIN) Producto <= prod_signed;
    end
  end

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// -----------------------------------------------------------------------------
// tb_multiplicador_algoritmico
//
// Directed self-checking bench for multiplicador_algoritmico with tamanyo=8.
// Expected products and latencies are hand-computed; latencies for the
// MULT_EARLY_EXIT_EN build are k+1 with k = index of the highest set bit of
// |B| plus 1 (k=1 for B=0).
// -----------------------------------------------------------------------------
module tb_multiplicador_algoritmico;

  localparam int T = 8;

  logic           CLK;
  logic           RSTa;
  logic           Start;
  logic [T-1:0]   A;
  logic [T-1:0]   B;
  logic [2*T-1:0] Producto;
  logic           Done;

  int checks = 0;
  int errors = 0;

  multiplicador_algoritmico #(.tamanyo(T)) dut (
    .CLK      (CLK),
    .RSTa     (RSTa),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Producto (Producto),
    .Done     (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pick the latency that applies to the build being simulated.
  function automatic int pick_lat(input int lat_full, input int lat_early);
`ifdef MULT_EARLY_EXIT_EN
    return lat_early;
`else
    return lat_full;
`endif
  endfunction

  // One Start pulse; operands are scrambled right after edge E to show they
  // are not re-sampled. Measures edges from E to Done.
  task automatic run_op(input string tag, input logic [T-1:0] a, input logic [T-1:0] b,
                        input logic [2*T-1:0] exp_p, input int lat_full, input int lat_early);
    int lat;
    logic [2*T-1:0] p;
    lat = 0;
    @(negedge CLK);
    Start = 1'b1; A = a; B = b;
    @(posedge CLK);            // edge E
    #1;
    Start = 1'b0; A = ~a; B = a ^ b ^ 8'h5A;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK); #1;
      if (Done) begin
        lat = i;
        break;
      end
    end
    p = Producto;
    check({tag, "_lat"}, 32'(lat), 32'(pick_lat(lat_full, lat_early)));
    check({tag, "_prod"}, 32'(p), 32'(exp_p));
    @(posedge CLK); #1;
    check({tag, "_done_width"}, 32'(Done), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    check({tag, "_hold"}, 32'(Producto), 32'(exp_p));
  endtask

  initial begin
    int pulses;
    int first, second, cyc;
    RSTa = 1'b1; Start = 1'b0; A = '0; B = '0;
    #3;
    check("reset_prod", 32'(Producto), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    @(negedge CLK); RSTa = 1'b0;

    //       tag       A       B       product   full early
    run_op("7x-3",     8'd7,   8'hFD,  16'hFFEB, 9,   3);
    run_op("m128sq",   8'h80,  8'h80,  16'h4000, 9,   9);
    run_op("m128x127", 8'h80,  8'h7F,  16'hC080, 9,   8);
    run_op("0x-5",     8'd0,   8'hFB,  16'h0000, 9,   4);
    run_op("-1x1",     8'hFF,  8'd1,   16'hFFFF, 9,   2);
    run_op("3x1",      8'd3,   8'd1,   16'h0003, 9,   2);

    // Extra Start during ITER, then asynchronous reset mid-operation.
    @(negedge CLK);
    Start = 1'b1; A = 8'd9; B = 8'd9;
    @(posedge CLK); #1; Start = 1'b0;
    @(posedge CLK); #1; Start = 1'b1; A = 8'd2; B = 8'd2;
    @(posedge CLK); #1; Start = 1'b0;
    #2; RSTa = 1'b1;
    #1;
    check("abort_prod", 32'(Producto), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    @(negedge CLK); RSTa = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (Done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_op("3x4", 8'd3, 8'd4, 16'h000C, 9, 4);

    // Start held high: back-to-back operations.
    @(negedge CLK);
    Start = 1'b1; A = 8'd5; B = 8'd6;
    first = 0; second = 0; cyc = 0;
    for (int i = 1; i <= 60 && second == 0; i++) begin
      @(posedge CLK); #1;
      if (Done) begin
        if (first == 0) begin
          first = i;
          check("held_prod1", 32'(Producto), 32'h001E);
        end else begin
          second = i;
          check("held_prod2", 32'(Producto), 32'h001E);
        end
        @(posedge CLK); #1;
        i++;
        check("held_done_width", 32'(Done), 32'd0);
      end
    end
    Start = 1'b0;
    if (second != 0) cyc = second - first;
    check("held_period", 32'(cyc), 32'(pick_lat(T + 2, 5)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
